// File: rtl/multi_ch_ctrl_fsm.sv
// multi_ch_ctrl_fsm
//   Sequences a start/done handshake across NCH datapath channels. In sequential
//   mode the channels are served one at a time, starting with channel 0. In
//   parallel mode all channels start together, and the operation completes once
//   every channel has reported done.
//
//   Optional feature: define MULTI_CH_CTRL_TIMEOUT_EN to enable the WAIT
//   timeout. When it fires, the FSM enters ERROR and raises a sticky error flag.
//   Without the macro, error is tied to 0 and ERROR is unreachable.
//
// Ports
//   clka      in   clock, rising edge
//   restart   in   synchronous active-high reset, highest priority
//   load      in   request an operation (accepted in IDLE or ERROR only)
//   mode      in   0 = sequential, 1 = parallel (latched with load)
//   done      in   [NCH] per-channel completion from the datapaths
//   start     out  [NCH] per-channel start, one cycle per START visit
//   state     out  [3] IDLE=0 START=1 WAIT=2 FIN=3 ERROR=4
//   cur_ch    out  [CW] channel being served in sequential mode
//   busy      out  high while state is START or WAIT
//   complete  out  one-cycle pulse when the operation finishes
//   error     out  timeout flag (0 unless the timeout feature is built in)
//
// start and complete are registered decodes of the state being left, so each
// appears one cycle after the state that produces it. busy and error are
// registered alongside the state, so they always agree with the state output.
module multi_ch_ctrl_fsm #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned CW      = 2,
  parameter int unsigned TO_W    = 8,
  parameter int unsigned TIMEOUT = 200
) (
  input  logic           clka,
  input  logic           restart,
  input  logic           load,
  input  logic           mode,
  input  logic [NCH-1:0] done,
  output logic [NCH-1:0] start,
  output logic [2:0]     state,
  output logic [CW-1:0]  cur_ch,
  output logic           busy,
  output logic           complete,
  output logic           error
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StWait  = 3'd2,
    StFin   = 3'd3,
    StError = 3'd4
  } state_e;

  if (NCH < 1 || NCH > 16 || TIMEOUT < 1 || TIMEOUT > (2 ** TO_W) - 1) begin : g_param_check
    $error("multi_ch_ctrl_fsm: illegal NCH/TIMEOUT/TO_W combination");
  end

  state_e         state_q;
  logic           mode_q;
  logic [CW-1:0]  cur_ch_q;
  logic [NCH-1:0] done_seen_q;
  logic [NCH-1:0] start_q;
  logic           busy_q;
  logic           complete_q;

  logic [NCH-1:0] ch_onehot;
  logic           last_ch;
  logic           wait_exit;

  always_comb begin
    ch_onehot           = '0;
    ch_onehot[cur_ch_q] = 1'b1;
    last_ch             = (cur_ch_q == CW'(NCH - 1));
    // Parallel completion includes this cycle's done bits, so a final bit
    // does not have to be accumulated first.
    wait_exit           = mode_q ? (&(done_seen_q | done)) : done[cur_ch_q];
  end

`ifdef MULTI_CH_CTRL_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q;
  logic            error_q;
`endif

  always_ff @(posedge clka) begin
    if (restart) begin
      state_q     <= StIdle;
      mode_q      <= 1'b0;
      cur_ch_q    <= '0;
      done_seen_q <= '0;
      start_q     <= '0;
      busy_q      <= 1'b0;
      complete_q  <= 1'b0;
`ifdef MULTI_CH_CTRL_TIMEOUT_EN
      to_cnt_q    <= '0;
      error_q     <= 1'b0;
`endif
    end else begin
      start_q    <= '0;
      complete_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (load) begin
            mode_q  <= mode;
            state_q <= StStart;
            busy_q  <= 1'b1;
          end
        end
        StStart: begin
          start_q <= mode_q ? '1 : ch_onehot;
          state_q <= StWait;
`ifdef MULTI_CH_CTRL_TIMEOUT_EN
          to_cnt_q <= '0;
`endif
        end
        StWait: begin
          if (mode_q) begin
            done_seen_q <= done_seen_q | done;
          end
          if (wait_exit) begin
            if (mode_q || last_ch) begin
              state_q <= StFin;
              busy_q  <= 1'b0;
            end else begin
              cur_ch_q <= cur_ch_q + 1'b1;
              state_q  <= StStart;
            end
          end
`ifdef MULTI_CH_CTRL_TIMEOUT_EN
          // Completion in the same cycle as the limit takes precedence.
          else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
            state_q <= StError;
            busy_q  <= 1'b0;
            error_q <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
`endif
        end
        StFin: begin
          complete_q  <= 1'b1;
          cur_ch_q    <= '0;
          done_seen_q <= '0;
          state_q     <= StIdle;
        end
`ifdef MULTI_CH_CTRL_TIMEOUT_EN
        StError: begin
          if (load) begin
            error_q     <= 1'b0;
            cur_ch_q    <= '0;
            done_seen_q <= '0;
            mode_q      <= mode;
            state_q     <= StStart;
            busy_q      <= 1'b1;
          end
        end
`endif
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign start    = start_q;
  assign state    = state_q;
  assign cur_ch   = cur_ch_q;
  assign busy     = busy_q;
  assign complete = complete_q;
`ifdef MULTI_CH_CTRL_TIMEOUT_EN
  assign error    = error_q;
`else
  assign error    = 1'b0;
`endif

endmodule

// File: tb/tb_multi_ch_ctrl_fsm.sv
module tb_multi_ch_ctrl_fsm;

  localparam int unsigned NCH = 4;

  logic           clka;
  logic           restart;
  logic           load;
  logic           mode;
  logic [NCH-1:0] done;
  logic [NCH-1:0] start;
  logic [2:0]     state;
  logic [1:0]     cur_ch;
  logic           busy;
  logic           complete;
  logic           error;

  int n_checks = 0;
  int n_fail   = 0;

  multi_ch_ctrl_fsm #(
    .NCH    (4),
    .CW     (2),
    .TO_W   (8),
    .TIMEOUT(10)
  ) u_dut (
    .clka    (clka),
    .restart (restart),
    .load    (load),
    .mode    (mode),
    .done    (done),
    .start   (start),
    .state   (state),
    .cur_ch  (cur_ch),
    .busy    (busy),
    .complete(complete),
    .error   (error)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  initial begin
    restart = 1'b1;
    load    = 1'b1;
    mode    = 1'b1;
    done    = '0;

    // Reset with load held high
    tick();
    tick();
    check_eq("rst_state", state, 0);
    check_eq("rst_start", start, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_complete", complete, 0);
    check_eq("rst_error", error, 0);
    check_eq("rst_cur_ch", cur_ch, 0);
    restart = 1'b0;
    load    = 1'b0;
    tick();
    check_eq("idle_hold", state, 0);

    // Sequential: done returned 3 cycles after each start
    load = 1'b1;
    mode = 1'b0;
    tick();
    load = 1'b0;
    mode = 1'b1;
    for (int ch = 0; ch < 4; ch++) begin
      check_eq("seq_in_start", state, 1);
      check_eq("seq_cur_ch", cur_ch, ch);
      check_eq("seq_start_lo", start, 0);
      check_eq("seq_busy", busy, 1);
      tick();
      check_eq("seq_start_onehot", start, 32'd1 << ch);
      check_eq("seq_in_wait", state, 2);
      for (int w = 0; w < 3; w++) begin
        if (ch == 0 && w == 1) begin
          // other channel's done and a stray load must be ignored
          done = 4'b0100;
          load = 1'b1;
        end
        tick();
        done = '0;
        load = 1'b0;
        check_eq("seq_wait_hold", state, 2);
        check_eq("seq_wait_ch", cur_ch, ch);
        check_eq("seq_wait_nostart", start, 0);
      end
      done[ch] = 1'b1;
      tick();
      done = '0;
    end
    check_eq("seq_fin", state, 3);
    check_eq("seq_fin_busy", busy, 0);
    check_eq("seq_fin_nocomplete", complete, 0);
    load = 1'b1; // ignored in FIN
    tick();
    load = 1'b0;
    check_eq("seq_idle", state, 0);
    check_eq("seq_complete", complete, 1);
    check_eq("seq_cur_ch_back", cur_ch, 0);
    tick();
    check_eq("seq_complete_once", complete, 0);
    check_eq("seq_no_reload", state, 0);
    check_eq("seq_no_restart", start, 0);

    // Parallel: done arrives as 0100, 0001, then 1010
    load = 1'b1;
    mode = 1'b1;
    tick();
    load = 1'b0;
    mode = 1'b0;
    check_eq("par_start_state", state, 1);
    tick();
    check_eq("par_start_all", start, 4'b1111);
    check_eq("par_wait", state, 2);
    done = 4'b0100;
    tick();
    done = 4'b0000;
    check_eq("par_nostart", start, 0);
    check_eq("par_wait1", state, 2);
    tick();
    check_eq("par_wait2", state, 2);
    done = 4'b0001;
    tick();
    check_eq("par_wait3", state, 2);
    done = 4'b1010;
    tick();
    done = '0;
    check_eq("par_fin", state, 3);
    check_eq("par_fin_nocomplete", complete, 0);
    tick();
    check_eq("par_complete", complete, 1);
    check_eq("par_idle", state, 0);
    tick();
    check_eq("par_complete_once", complete, 0);

    // Mid-operation restart while serving channel 2
    load = 1'b1;
    mode = 1'b0;
    tick();
    load = 1'b0;
    for (int ch = 0; ch < 2; ch++) begin
      tick();
      done[ch] = 1'b1;
      tick();
      done = '0;
    end
    check_eq("mid_start_ch2", state, 1);
    tick();
    check_eq("mid_wait_ch2", state, 2);
    check_eq("mid_cur_ch2", cur_ch, 2);
    check_eq("mid_start_bit2", start, 4'b0100);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check_eq("mid_rst_state", state, 0);
    check_eq("mid_rst_cur_ch", cur_ch, 0);
    check_eq("mid_rst_start", start, 0);
    check_eq("mid_rst_busy", busy, 0);
    load = 1'b1;
    tick();
    load = 1'b0;
    check_eq("mid_reload_ch", cur_ch, 0);
    tick();
    check_eq("mid_reload_start", start, 4'b0001);
    restart = 1'b1;
    tick();
    restart = 1'b0;

`ifdef MULTI_CH_CTRL_TIMEOUT_EN
    // Timeout with no done: ERROR after 10 WAIT cycles
    load = 1'b1;
    mode = 1'b1;
    tick();
    load = 1'b0;
    tick();
    check_eq("to_wait", state, 2);
    repeat (9) tick();
    check_eq("to_still_wait", state, 2);
    check_eq("to_no_error_yet", error, 0);
    tick();
    check_eq("to_error_state", state, 4);
    check_eq("to_error_flag", error, 1);
    check_eq("to_error_busy", busy, 0);
    done = '1;
    tick();
    tick();
    done = '0;
    check_eq("to_error_sticky", error, 1);
    check_eq("to_error_hold", state, 4);
    check_eq("to_error_nostart", start, 0);

    // load from ERROR restarts; completion on the limit cycle wins
    load = 1'b1;
    mode = 1'b1;
    tick();
    load = 1'b0;
    check_eq("to_reload_state", state, 1);
    check_eq("to_reload_error", error, 0);
    tick();
    check_eq("to_reload_start", start, 4'b1111);
    repeat (9) tick();
    check_eq("to_limit_wait", state, 2);
    done = '1;
    tick();
    done = '0;
    check_eq("to_tie_fin", state, 3);
    check_eq("to_tie_no_error", error, 0);
    tick();
    check_eq("to_tie_complete", complete, 1);
`else
    // Without the timeout, WAIT persists indefinitely and error stays low
    load = 1'b1;
    mode = 1'b1;
    tick();
    load = 1'b0;
    repeat (300) tick();
    check_eq("noto_wait", state, 2);
    check_eq("noto_error", error, 0);
    check_eq("noto_busy", busy, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
